// File: rtl/dmi_arbiter.sv
// dmi_arbiter: round-robin arbiter sharing one Debug Module DMI target
// between NREQ requesters. One transaction in flight at a time; the DM
// response is returned to the requester that issued it. A per-requester
// clear aborts delivery, and an optional timeout synthesises a failed
// response and marks the DM link stale until a late response drains.
module dmi_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned REQ_W   = 41,
  parameter int unsigned RESP_W  = 34,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ*REQ_W-1:0]  req_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ-1:0]        clear_i,
  output logic [RESP_W-1:0]      resp_o,
  output logic [NREQ-1:0]        resp_valid_o,
  input  logic [NREQ-1:0]        resp_ready_i,
  output logic [REQ_W-1:0]       dm_req_o,
  output logic                   dm_req_valid_o,
  input  logic                   dm_req_ready_i,
  input  logic [RESP_W-1:0]      dm_resp_i,
  input  logic                   dm_resp_valid_i,
  output logic                   dm_resp_ready_o
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]     CNT_LAST  = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [RESP_W-1:0] RESP_FAIL = RESP_W'(2'b10);
  localparam logic [OW-1:0]     LAST_IDX  = OW'(NREQ - 1);
  localparam logic [OW:0]       NREQ_W    = (OW+1)'(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RET
  } state_e;

  state_e            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              stale_q, stale_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              discard_q, discard_d;
  logic [REQ_W-1:0]  dm_req_q, dm_req_d;
  logic [RESP_W-1:0] resp_q, resp_d;

  logic [REQ_W-1:0]  req_arr [NREQ];
  logic              grant_vld;
  logic [OW-1:0]     grant_idx;
  logic [OW:0]       rr_sum;
  logic [OW-1:0]     rr_cand;
  logic [OW-1:0]     nxt_owner;
  logic [NREQ-1:0]   owner_oh;
  logic              clear_own;
  logic              drop;
  logic              go_idle;

  // Unpack the flat request bus into one payload per requester.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_arr[i] = req_i[i*REQ_W +: REQ_W];
    end
  end

  // Round-robin pick: first valid, non-cleared requester from rr_ptr upward.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rr_sum = {1'b0, rr_ptr_q} + (OW+1)'(i);
      if (rr_sum >= NREQ_W) begin
        rr_sum = rr_sum - NREQ_W;
      end
      rr_cand = rr_sum[OW-1:0];
      if (!grant_vld && req_valid_i[rr_cand] && !clear_i[rr_cand]) begin
        grant_vld = 1'b1;
        grant_idx = rr_cand;
      end
    end
  end

  assign nxt_owner = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  assign owner_oh  = NREQ'(1'b1) << owner_q;
  assign clear_own = clear_i[owner_q];
  assign drop      = discard_q | clear_own;
  assign dm_req_o  = dm_req_q;
  assign resp_o    = resp_q;

  // Next-state and output decode for the transaction FSM.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_ptr_d        = rr_ptr_q;
    stale_d         = stale_q;
    cnt_d           = cnt_q;
    discard_d       = discard_q;
    dm_req_d        = dm_req_q;
    resp_d          = resp_q;
    req_ready_o     = '0;
    resp_valid_o    = '0;
    dm_req_valid_o  = 1'b0;
    dm_resp_ready_o = stale_q;
    go_idle         = 1'b0;

    // A stale link swallows any late DM response; resp_d is untouched here.
    if (stale_q && dm_resp_valid_i) begin
      stale_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (stale_q) begin
          if (|clear_i) begin
            stale_d = 1'b0;
          end
        end else if (grant_vld && !rst_i) begin
          req_ready_o[grant_idx] = 1'b1;
          owner_d                = grant_idx;
          dm_req_d               = req_arr[grant_idx];
          state_d                = S_REQ;
        end
      end

      S_REQ: begin
        dm_req_valid_o = 1'b1;
        if (clear_own) begin
          discard_d = 1'b1;
        end
        if (dm_req_ready_i) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end

      S_WAIT: begin
        dm_resp_ready_o = 1'b1;
        if (dm_resp_valid_i) begin
          resp_d = dm_resp_i;
          if (drop) begin
            go_idle = 1'b1;
          end else begin
            state_d = S_RET;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          resp_d  = RESP_FAIL;
          stale_d = 1'b1;
          if (drop) begin
            go_idle = 1'b1;
          end else begin
            state_d = S_RET;
          end
        end else begin
          cnt_d     = cnt_q + 1'b1;
          discard_d = drop;
        end
      end

      S_RET: begin
        resp_valid_o = owner_oh;
        if (resp_ready_i[owner_q] || clear_own) begin
          go_idle = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_idle) begin
      state_d   = S_IDLE;
      rr_ptr_d  = nxt_owner;
      discard_d = 1'b0;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      stale_q   <= 1'b0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      dm_req_q  <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      stale_q   <= stale_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
      dm_req_q  <= dm_req_d;
      resp_q    <= resp_d;
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter: directed stimulus for dmi_arbiter with a transaction-level
// reference model compared on every falling edge, plus literal expectations.
module tb_dmi_arbiter;

  localparam int NREQ   = 2;
  localparam int REQ_W  = 41;
  localparam int RESP_W = 34;
  localparam int TO     = 8;

  logic                  clk;
  logic                  rst;
  logic [NREQ*REQ_W-1:0] req;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ-1:0]       clear;
  logic [RESP_W-1:0]     resp_o;
  logic [NREQ-1:0]       resp_valid_o;
  logic [NREQ-1:0]       resp_ready;
  logic [REQ_W-1:0]      dm_req_o;
  logic                  dm_req_valid_o;
  logic                  dm_req_ready;
  logic [RESP_W-1:0]     dm_resp;
  logic                  dm_resp_valid;
  logic                  dm_resp_ready_o;

  int checks;
  int errors;
  int grants[$];

  logic [REQ_W-1:0]  pay0, payA, payB, payC;
  logic [RESP_W-1:0] rtmp;

  dmi_arbiter #(
    .NREQ(NREQ),
    .REQ_W(REQ_W),
    .RESP_W(RESP_W),
    .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_i(req),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready_o),
    .clear_i(clear),
    .resp_o(resp_o),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready),
    .dm_req_o(dm_req_o),
    .dm_req_valid_o(dm_req_valid_o),
    .dm_req_ready_i(dm_req_ready),
    .dm_resp_i(dm_resp),
    .dm_resp_valid_i(dm_resp_valid),
    .dm_resp_ready_o(dm_resp_ready_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: one transaction record (active / issued to DM /
  // response held for requester) plus the round-robin start and stale flag.
  logic              m_active, m_issued, m_have, m_stale, m_drop;
  int                m_owner, m_next, m_wait;
  logic [REQ_W-1:0]  m_pay;
  logic [RESP_W-1:0] m_resp;
  int                pick;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input logic [NREQ-1:0] c,
                                 input int from);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (from + k) % NREQ;
      if (v[j] && !c[j]) return j;
    end
    return -1;
  endfunction

  assign pick = rr_pick(req_valid, clear, m_next);

  logic [NREQ-1:0]   exp_req_ready, exp_resp_valid;
  logic              exp_dm_req_valid, exp_dm_resp_ready;
  assign exp_req_ready     = (!rst && !m_active && !m_stale && pick >= 0) ? (NREQ'(1) << pick) : '0;
  assign exp_dm_req_valid  = m_active && !m_issued;
  assign exp_dm_resp_ready = m_stale || (m_active && m_issued && !m_have);
  assign exp_resp_valid    = (m_active && m_have) ? (NREQ'(1) << m_owner) : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_issued <= 1'b0; m_have <= 1'b0;
      m_stale  <= 1'b0; m_drop   <= 1'b0;
      m_owner  <= 0; m_next <= 0; m_wait <= 0;
      m_pay    <= '0; m_resp <= '0;
    end else if (!m_active) begin
      if (m_stale) begin
        if (dm_resp_valid || (|clear)) m_stale <= 1'b0;
      end else if (pick >= 0) begin
        m_active <= 1'b1; m_issued <= 1'b0; m_have <= 1'b0; m_drop <= 1'b0;
        m_owner  <= pick;
        m_pay    <= req[pick*REQ_W +: REQ_W];
      end
    end else if (!m_issued) begin
      if (clear[m_owner]) m_drop <= 1'b1;
      if (dm_req_ready) begin
        m_issued <= 1'b1;
        m_wait   <= 0;
      end
    end else if (!m_have) begin
      if (dm_resp_valid || m_wait == TO - 1) begin
        m_resp <= dm_resp_valid ? dm_resp : RESP_W'(2);
        if (!dm_resp_valid) m_stale <= 1'b1;
        if (m_drop || clear[m_owner]) begin
          m_active <= 1'b0;
          m_next   <= (m_owner + 1) % NREQ;
        end else begin
          m_have <= 1'b1;
        end
      end else begin
        m_wait <= m_wait + 1;
        if (clear[m_owner]) m_drop <= 1'b1;
      end
    end else begin
      if (m_stale && dm_resp_valid) m_stale <= 1'b0;
      if (resp_ready[m_owner] || clear[m_owner]) begin
        m_active <= 1'b0;
        m_next   <= (m_owner + 1) % NREQ;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Drive an auto-responding DM and ready requesters until a response is
  // delivered, then return to IDLE.
  task automatic finish_txn();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      dm_req_ready  = 1'b1;
      dm_resp_valid = 1'b1;
      dm_resp       = {32'hA5A5_0000 + 32'(i), 2'b01};
      resp_ready    = 2'b11;
      neg();
      if (resp_valid_o != '0) seen = 1'b1;
      tick();
    end
    chk("finish_bound", 64'(seen), 64'd1);
    dm_req_ready  = 1'b0;
    dm_resp_valid = 1'b0;
    resp_ready    = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; req = '0; req_valid = 2'b11; clear = '0; resp_ready = '0;
    dm_req_ready = 1'b0; dm_resp = '0; dm_resp_valid = 1'b0;
    pay0 = {7'h10, 32'hDEADBEEF, 2'b10};
    payA = {7'h01, 32'h1111_1111, 2'b01};
    payB = {7'h02, 32'h2222_2222, 2'b10};
    payC = {7'h22, 32'hCAFEF00D, 2'b01};

    fork
      begin : compare
        forever begin
          neg();
          chk("m_req_ready", 64'(req_ready_o), 64'(exp_req_ready));
          chk("m_dm_req_valid", 64'(dm_req_valid_o), 64'(exp_dm_req_valid));
          chk("m_dm_req", 64'(dm_req_o), 64'(m_pay));
          chk("m_dm_resp_ready", 64'(dm_resp_ready_o), 64'(exp_dm_resp_ready));
          chk("m_resp_valid", 64'(resp_valid_o), 64'(exp_resp_valid));
          chk("m_resp", 64'(resp_o), 64'(m_resp));
        end
      end
      begin : watchdog
        #100000;
        errors++;
        $display("FAIL watchdog time limit reached");
      end
      begin : stim
        // reset values with requests pending
        neg();
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_dm_resp_ready", 64'(dm_resp_ready_o), 64'd0);
        chk("rst_dm_req", 64'(dm_req_o), 64'd0);
        tick();
        rst = 1'b0; req_valid = '0;
        tick();

        // single write from requester 0, DM answers immediately
        req[0*REQ_W +: REQ_W] = pay0; req_valid = 2'b01; dm_req_ready = 1'b1;
        neg(); chk("t1_accept", 64'(req_ready_o), 64'd1);
        tick(); req_valid = '0;
        neg(); chk("t1_dm_valid", 64'(dm_req_valid_o), 64'd1);
        chk("t1_dm_req", 64'(dm_req_o), 64'(pay0));
        tick(); dm_resp_valid = 1'b1; dm_resp = '0;
        neg(); chk("t1_dm_resp_ready", 64'(dm_resp_ready_o), 64'd1);
        chk("t1_no_resp_yet", 64'(resp_valid_o), 64'd0);
        tick(); dm_resp_valid = 1'b0;
        neg(); chk("t1_resp_valid", 64'(resp_valid_o), 64'd1);
        chk("t1_resp", 64'(resp_o), 64'd0);
        resp_ready = 2'b01;
        tick(); resp_ready = '0;
        neg(); chk("t1_resp_done", 64'(resp_valid_o), 64'd0);

        // round-robin with both requesters continuously valid, from rr_ptr=0
        rst = 1'b1; tick(); rst = 1'b0;
        req[0*REQ_W +: REQ_W] = payA; req[1*REQ_W +: REQ_W] = payB;
        req_valid = 2'b11; resp_ready = 2'b11;
        for (int i = 0; i < 40 && grants.size() < 4; i++) begin
          dm_req_ready = 1'b1; dm_resp_valid = 1'b1; dm_resp = {32'h100 + 32'(i), 2'b01};
          neg();
          if (req_ready_o != '0) grants.push_back(req_ready_o[1] ? 1 : 0);
          tick();
        end
        req_valid = '0;
        finish_txn();
        chk("t2_grant_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size(); i++) chk("t2_grant_order", 64'(grants[i]), 64'(i % 2));

        // timeout: DM never answers; link goes stale until a late response
        req_valid = 2'b01; dm_req_ready = 1'b1; dm_resp_valid = 1'b0;
        neg(); chk("t3_grant", 64'(req_ready_o), 64'd1);
        tick(); req_valid = '0;
        tick();
        for (int w = 0; w < TO; w++) begin
          neg(); chk("t3_wait_no_resp", 64'(resp_valid_o), 64'd0);
          tick();
        end
        neg(); chk("t3_to_valid", 64'(resp_valid_o), 64'd1);
        rtmp = resp_o;
        chk("t3_to_code", 64'(rtmp[1:0]), 64'd2);
        chk("t3_to_resp", 64'(resp_o), 64'd2);
        req_valid = 2'b11; resp_ready = 2'b01;
        tick(); resp_ready = '0;
        for (int w = 0; w < 3; w++) begin
          neg(); chk("t3_blocked", 64'(req_ready_o), 64'd0);
          chk("t3_stale_ready", 64'(dm_resp_ready_o), 64'd1);
          tick();
        end
        dm_resp_valid = 1'b1; dm_resp = '1;
        neg(); chk("t3_still_blocked", 64'(req_ready_o), 64'd0);
        tick(); dm_resp_valid = 1'b0;
        neg(); chk("t3_resp_kept", 64'(resp_o), 64'd2);
        chk("t3_regrant", 64'(req_ready_o), 64'd2);
        tick(); req_valid = '0;
        finish_txn();

        // clear of requester 1 while waiting on the DM
        req[1*REQ_W +: REQ_W] = payB; req_valid = 2'b10; dm_req_ready = 1'b1;
        neg(); chk("t4_grant", 64'(req_ready_o), 64'd2);
        tick(); req_valid = '0;
        tick(); clear = 2'b10;
        neg(); chk("t4_wait", 64'(dm_resp_ready_o), 64'd1);
        tick(); clear = '0; dm_resp_valid = 1'b1; dm_resp = {32'h1234, 2'b00};
        neg(); chk("t4_consume", 64'(dm_resp_ready_o), 64'd1);
        tick(); dm_resp_valid = 1'b0; req_valid = 2'b11;
        neg(); chk("t4_no_resp", 64'(resp_valid_o), 64'd0);
        chk("t4_next_grant", 64'(req_ready_o), 64'd1);
        tick(); req_valid = '0;
        finish_txn();

        // DM back-pressure for five cycles
        req[1*REQ_W +: REQ_W] = payC; req_valid = 2'b11; dm_req_ready = 1'b0;
        neg(); chk("t5_grant", 64'(req_ready_o), 64'd2);
        tick();
        for (int w = 0; w < 5; w++) begin
          neg(); chk("t5_dm_valid", 64'(dm_req_valid_o), 64'd1);
          chk("t5_dm_req", 64'(dm_req_o), 64'(payC));
          chk("t5_no_ready", 64'(req_ready_o), 64'd0);
          tick();
        end
        req_valid = '0; dm_req_ready = 1'b1;
        tick(); dm_resp_valid = 1'b1; dm_resp = {32'h55, 2'b00};
        tick(); dm_resp_valid = 1'b0; req_valid = 2'b11;
        neg(); chk("t5_ret", 64'(resp_valid_o), 64'd2);

        // asynchronous reset while returning a response
        #2 rst = 1'b1;
        #1;
        chk("t6_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("t6_resp", 64'(resp_o), 64'd0);
        chk("t6_dm_req", 64'(dm_req_o), 64'd0);
        chk("t6_dm_req_valid", 64'(dm_req_valid_o), 64'd0);
        chk("t6_dm_resp_ready", 64'(dm_resp_ready_o), 64'd0);
        chk("t6_req_ready", 64'(req_ready_o), 64'd0);
        tick(); rst = 1'b0;
        neg(); chk("t6_grant_rr0", 64'(req_ready_o), 64'd1);
        tick(); req_valid = '0;
        finish_txn();
        tick();
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
- Shares a single debug-side DMI target (the Debug Module) between NREQ DMI requesters, e.g. the JTAG DTM CDC output and a system-bus debug bridge.
- Runs entirely in the DM clock domain and sits after the request/response CDC stages.
- Serialises transactions, with one outstanding transaction at a time. Arbitration is round-robin.
- Routes each DM response back to the requester that issued the request. Provides per-requester clear and a response timeout.

Parameters:
- NREQ, 2, number of requesters (2..4).
- REQ_W, 41, packed request width {addr[6:0], data[31:0], op[1:0]}.
- RESP_W, 34, packed response width {data[31:0], resp[1:0]}.
- TIMEOUT, 1024, maximum cycles to wait for a DM response; 0 disables the timeout.

Ports:
- clk_i  in  1  DM clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  NREQ*REQ_W  request payload per requester.
- req_valid_i  in  NREQ  request valid per requester.
- req_ready_o  out  NREQ  request accepted (one-hot or zero).
- clear_i  in  NREQ  per-requester abort/clear, level-sampled.
- resp_o  out  RESP_W  registered response, shared by all requesters.
- resp_valid_o  out  NREQ  response valid toward the owning requester (one-hot or zero).
- resp_ready_i  in  NREQ  response ready per requester.
- dm_req_o  out  REQ_W  request payload to the DM.
- dm_req_valid_o  out  1  request valid to the DM.
- dm_req_ready_i  in  1  DM request ready.
- dm_resp_i  in  RESP_W  DM response payload.
- dm_resp_valid_i  in  1  DM response valid.
- dm_resp_ready_o  out  1  response ready to the DM.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, owner=0, rr_ptr=0, stale=0, cnt=0, discard=0.
  - All *_valid_o and *_ready_o are 0; dm_req_o=0, resp_o=0.
- FSM states: IDLE, REQ, WAIT, RET.
- IDLE:
  - If stale=0, grant the first requester with req_valid_i=1 and clear_i=0, searching from rr_ptr upward with wrap.
  - req_ready_o[winner]=1 combinationally in the same cycle; this completes the handshake.
  - Latch owner=winner and dm_req_o=req_i[winner]; go to REQ.
  - No winner → stay in IDLE.
- REQ:
  - dm_req_valid_o=1; the payload is held stable.
  - When dm_req_ready_i=1 → go to WAIT and set cnt=0.
  - A clear here does not drop the request: set discard=1 and continue.
- WAIT:
  - dm_resp_ready_o=1.
  - On dm_resp_valid_i=1, latch resp_o=dm_resp_i. Then:
    - discard=1 → IDLE.
    - otherwise → RET.
  - Otherwise cnt increments.
  - If TIMEOUT≠0 and cnt==TIMEOUT-1 with no valid:
    - set resp_o={32'h0, 2'b10} (failed) and stale=1;
    - go to RET, or to IDLE if discard=1.
  - A response arriving in the same cycle as the timeout wins.
  - clear_i[owner] sets discard=1 and stays in WAIT.
- RET:
  - resp_valid_o[owner]=1; resp_o is held stable.
  - On resp_ready_i[owner] → IDLE.
  - clear_i[owner]=1 → IDLE immediately; resp_valid_o drops the next cycle.
- rr_ptr update: on every exit to IDLE from WAIT or RET, rr_ptr=(owner+1) mod NREQ.
- On entering IDLE, discard=0.
- stale handling:
  - While stale=1, dm_resp_ready_o=1 in every state.
  - Any dm_resp_valid_i is consumed, discarded, and clears stale. This never updates resp_o outside WAIT.
  - Any clear_i bit in IDLE also clears stale.
- Latency, no contention, DM ready and responding immediately: requester accept at cycle 0, dm_req_valid_o at cycle 1, WAIT at cycle 2, resp_valid_o at cycle 3 earliest.
- Requester clear_i while not owner: that requester is masked from arbitration that cycle; no other effect.
- Simultaneous req_valid_i: exactly one grant per IDLE cycle; no requester starves (round-robin).
- Reset mid-transaction: all state is dropped; the DM may hold an orphan response, which the DM's own clear must handle.

Test Plan:
- Single requester 0 writes addr 7'h10, data 32'hDEADBEEF, op 2'b10; DM ready=1, resp={32'h0,2'b00} one cycle after accept → resp_valid_o=2'b01 three cycles after req_ready_o[0], resp_o=34'h0.
- Both requesters continuously valid with rr_ptr=0 → grant order 0,1,0,1 across 4 transactions; resp_valid_o never goes to the wrong requester.
- TIMEOUT=8, DM never responds → after 8 WAIT cycles, resp_valid_o[owner]=1 with resp_o[1:0]=2'b10. Next request blocked until a late dm_resp_valid_i pulse, which is discarded; then the grant proceeds.
- clear_i[1] asserted in WAIT of requester 1's transaction → DM response (data 32'h1234) is consumed, resp_valid_o stays 0, FSM returns to IDLE, and requester 0 is granted next.
- dm_req_ready_i held 0 for 5 cycles → dm_req_valid_o=1 and dm_req_o stable throughout, and no req_ready_o is asserted to any requester.
- rst_i asserted during RET → all outputs 0 asynchronously; after release the FSM is in IDLE with rr_ptr=0.
